// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the SPI serial-memory protocol.
// The initiator side imports the same command constants.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int         ADDR_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RDATA,
    WDATA,
    DONE,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_mem_responder_if.sv
// SPI pin bundle between initiator (master) and memory responder (slave).
interface spi_mem_responder_if;

  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// N-flop input synchronizer with rise/fall detection on the last two synced samples.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // One flop beyond the synchronizer holds the previous synced sample.
  logic [STAGES:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {(STAGES + 1){RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-1:0], d_i};
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~sync_q[STAGES];
  assign fall_o = ~sync_q[STAGES-1] & sync_q[STAGES];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 READ/WRITE memory responder with oversampled pins and a preload port.
// Define SPI_MEM_BURST_EN to stream consecutive bytes with address auto-increment.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int MEM_AW      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_mem_responder_if.slave    spi,
  input  logic                  ld_en,
  input  logic [MEM_AW-1:0]     ld_addr,
  input  logic [7:0]            ld_data,
  output logic                  busy,
  output logic                  txn_done,
  output logic                  cmd_err
);

  // Upper address bits alias, so only enough bits for a byte or an address are kept.
  localparam int RX_W = (MEM_AW > 8) ? MEM_AW : 8;

  logic       sclk_rise, sclk_fall, cs_n_s, mosi_s;
  logic [4:0] edge_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(spi.sclk),
    .q_o(edge_unused[0]), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(spi.cs_n),
    .q_o(cs_n_s), .rise_o(edge_unused[1]), .fall_o(edge_unused[2])
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(spi.mosi),
    .q_o(mosi_s), .rise_o(edge_unused[3]), .fall_o(edge_unused[4])
  );

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [RX_W-2:0]   rx_q, rx_d;
  logic [RX_W-1:0]   rx_shift;
  logic              is_read_q, is_read_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic              tx_load_q, tx_load_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              txn_done_q, txn_done_d;
  logic              cmd_err_q, cmd_err_d;
  logic              wr_pend_q, wr_pend_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [MEM_AW-1:0] rd_addr;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem [2**MEM_AW];

  assign rx_shift = {rx_q, mosi_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    tx_load_d  = 1'b0;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    txn_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    wr_pend_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr    = addr_q;

    // Registered memory read lands one clk after the request.
    if (tx_load_q) tx_d = rd_data_q;
    if (wr_pend_q) txn_done_d = 1'b1;

    if (cs_n_s) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = 4'd7;
        end
        CMD: if (sclk_rise) begin
          rx_d      = rx_shift[RX_W-2:0];
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'(ADDR_BITS - 1);
            if (rx_shift[7:0] == CMD_READ) begin
              state_d   = ADDR;
              is_read_d = 1'b1;
            end else if (rx_shift[7:0] == CMD_WRITE) begin
              state_d   = ADDR;
              is_read_d = 1'b0;
            end else begin
              state_d   = IGNORE;
              cmd_err_d = 1'b1;
            end
          end
        end
        ADDR: if (sclk_rise) begin
          rx_d      = rx_shift[RX_W-2:0];
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd0) begin
            addr_d    = rx_shift[MEM_AW-1:0];
            bit_cnt_d = 4'd7;
            if (is_read_q) begin
              rd_addr   = rx_shift[MEM_AW-1:0];
              tx_load_d = 1'b1;
              state_d   = RDATA;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (sclk_fall) begin
            miso_d    = tx_q[7];
            miso_oe_d = 1'b1;
            tx_d      = {tx_q[6:0], 1'b0};
          end else if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            if (bit_cnt_q == 4'd0) begin
              txn_done_d = 1'b1;
`ifdef SPI_MEM_BURST_EN
              addr_d    = addr_q + 1'b1;
              rd_addr   = addr_q + 1'b1;
              tx_load_d = 1'b1;
              bit_cnt_d = 4'd7;
`else
              state_d = DONE;
`endif
            end
          end
        end
        WDATA: if (sclk_rise) begin
          rx_d      = rx_shift[RX_W-2:0];
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd0) begin
            wr_pend_d = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_shift[7:0];
`ifdef SPI_MEM_BURST_EN
            addr_d    = addr_q + 1'b1;
            bit_cnt_d = 4'd7;
`else
            state_d = DONE;
`endif
          end
        end
        DONE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      tx_load_q  <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      txn_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      tx_load_q  <= tx_load_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      txn_done_q <= txn_done_d;
      cmd_err_q  <= cmd_err_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Contents survive reset; preload only while the bus is deselected.
  always_ff @(posedge clk) begin
    if (wr_pend_q) begin
      mem[wr_addr_q] <= wr_data_q;
    end else if (ld_en && cs_n_s) begin
      mem[ld_addr] <= ld_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign busy        = ~cs_n_s;
  assign txn_done    = txn_done_q;
  assign cmd_err     = cmd_err_q;
  assign spi.miso    = miso_q;
  assign spi.miso_oe = miso_oe_q;

endmodule
